// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and helpers for the I2C master engine.
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR_W,
        S_ACK_A,
        S_SUB,
        S_ACK_S,
        S_WDATA,
        S_ACK_D,
        S_RSTART,
        S_ADDR_R,
        S_ACK_R,
        S_RDATA,
        S_MNACK,
        S_STOP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } qphase_t;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

    function automatic int calc_qdiv(input int clk_hz, input int scl_hz);
        int q;
        q = clk_hz / (4 * scl_hz);
        return (q < 2) ? 2 : q;
    endfunction

endpackage

// File: rtl/i2c_qtick.sv
// i2c_qtick: quarter-SCL-period tick generator with optional stretch hold.
// Hold on a low SCL is compiled in with `define I2C_CLOCK_STRETCH_EN.
module i2c_qtick #(
    parameter int QDIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    input  logic hold_ok,
    input  logic scl_in,
    output logic tick
);

    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

    logic [CW-1:0] cnt;
    logic          hold;

`ifdef I2C_CLOCK_STRETCH_EN
    // A slave still holding SCL low after release freezes the bit timing.
    assign hold = hold_ok && !scl_in;
`else
    logic unused_stretch;
    assign unused_stretch = hold_ok ^ scl_in;
    assign hold = 1'b0;
`endif

    assign tick = run && !hold && (cnt == CW'(QDIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run && !hold) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master_engine.sv
// i2c_master_engine: byte-level I2C master, one register write or read per command.
// Slave clock stretching is enabled with `define I2C_CLOCK_STRETCH_EN.
module i2c_master_engine
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int I2C_FREQ_HZ = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] addr,
    input  logic [7:0] sub_addr,
    input  logic [7:0] data_wr,
    output logic [7:0] data_rd,
    output logic       busy,
    output logic       ack_err,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_oe,
    output logic       scl_oe
);

    localparam int QDIV = calc_qdiv(CLK_FREQ_HZ, I2C_FREQ_HZ);

    state_t     state;
    state_t     nstate;
    qphase_t    q;
    logic [2:0] bitcnt;
    logic [7:0] addr_r;
    logic [7:0] sub_r;
    logic [7:0] wdata_r;
    logic [7:0] rx_sh;
    logic [7:0] tx_byte;
    logic       samp;
    logic       tick;
    logic       run;
    logic       hold_ok;
    logic       slot_end;
    logic       byte_end;
    logic       scl_lo;
    logic       tx_bit;
    logic       scl_drv;
    logic       sda_drv;
    logic       in_ack;
    logic       in_byte;

    assign busy     = (state != S_IDLE);
    assign run      = (state != S_IDLE) && (state != S_DONE);
    assign hold_ok  = (q == Q2) && !scl_oe;
    assign scl_lo   = (q == Q0) || (q == Q1);
    assign slot_end = tick && (q == Q3);
    assign byte_end = slot_end && (bitcnt == 3'd0);
    assign tx_bit   = tx_byte[bitcnt];
    assign in_ack   = state inside {S_ACK_A, S_ACK_S, S_ACK_D, S_ACK_R};
    assign in_byte  = state inside {S_ADDR_W, S_SUB, S_WDATA,
                                    S_ADDR_R, S_RDATA};

    i2c_qtick #(
        .QDIV(QDIV)
    ) u_qtick (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == S_IDLE),
        .run    (run),
        .hold_ok(hold_ok),
        .scl_in (scl_in),
        .tick   (tick)
    );

    always_comb begin
        tx_byte = 8'h00;
        unique case (state)
            S_ADDR_W: tx_byte = {addr_r[7:1], I2C_WR};
            S_SUB:    tx_byte = sub_r;
            S_WDATA:  tx_byte = wdata_r;
            S_ADDR_R: tx_byte = {addr_r[7:1], I2C_RD};
            default:  tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate  = state;
        scl_drv = 1'b0;
        sda_drv = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (ena) nstate = S_START;
            end
            S_START: begin
                sda_drv = (q == Q2) || (q == Q3);
                if (slot_end) nstate = S_ADDR_W;
            end
            S_ADDR_W: begin
                scl_drv = scl_lo;
                sda_drv = !tx_bit;
                if (byte_end) nstate = S_ACK_A;
            end
            S_ACK_A: begin
                scl_drv = scl_lo;
                if (slot_end) nstate = samp ? S_STOP : S_SUB;
            end
            S_SUB: begin
                scl_drv = scl_lo;
                sda_drv = !tx_bit;
                if (byte_end) nstate = S_ACK_S;
            end
            S_ACK_S: begin
                scl_drv = scl_lo;
                if (slot_end) begin
                    if (samp)
                        nstate = S_STOP;
                    else if (addr_r[0] == I2C_RD)
                        nstate = S_RSTART;
                    else
                        nstate = S_WDATA;
                end
            end
            S_WDATA: begin
                scl_drv = scl_lo;
                sda_drv = !tx_bit;
                if (byte_end) nstate = S_ACK_D;
            end
            S_ACK_D: begin
                scl_drv = scl_lo;
                if (slot_end) nstate = S_STOP;
            end
            S_RSTART: begin
                // SDA released while SCL low, then pulled low with SCL high
                scl_drv = scl_lo;
                sda_drv = (q == Q3);
                if (slot_end) nstate = S_ADDR_R;
            end
            S_ADDR_R: begin
                scl_drv = scl_lo;
                sda_drv = !tx_bit;
                if (byte_end) nstate = S_ACK_R;
            end
            S_ACK_R: begin
                scl_drv = scl_lo;
                if (slot_end) nstate = samp ? S_STOP : S_RDATA;
            end
            S_RDATA: begin
                scl_drv = scl_lo;
                if (byte_end) nstate = S_MNACK;
            end
            S_MNACK: begin
                scl_drv = scl_lo;
                if (slot_end) nstate = S_STOP;
            end
            S_STOP: begin
                scl_drv = scl_lo;
                sda_drv = (q != Q3);
                if (slot_end) nstate = S_DONE;
            end
            S_DONE: begin
                nstate = S_IDLE;
            end
            default: begin
                nstate = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= Q0;
            bitcnt  <= 3'd7;
            addr_r  <= 8'h00;
            sub_r   <= 8'h00;
            wdata_r <= 8'h00;
            rx_sh   <= 8'h00;
            samp    <= 1'b0;
            ack_err <= 1'b0;
            data_rd <= 8'h00;
            sda_oe  <= 1'b0;
            scl_oe  <= 1'b0;
        end else begin
            sda_oe <= sda_drv;
            scl_oe <= scl_drv;
            if (state == S_IDLE) begin
                q      <= Q0;
                bitcnt <= 3'd7;
                if (ena) begin
                    addr_r  <= addr;
                    sub_r   <= sub_addr;
                    wdata_r <= data_wr;
                    ack_err <= 1'b0;
                end
            end else if (tick) begin
                q <= qphase_t'(q + 2'd1);
                if (q == Q2) begin
                    samp <= sda_in;
                    if (state == S_RDATA) rx_sh <= {rx_sh[6:0], sda_in};
                end
                if (q == Q3) begin
                    // wraps 0 -> 7, leaving the counter ready for the next byte
                    if (in_byte) bitcnt <= bitcnt - 3'd1;
                    if (in_ack && samp) ack_err <= 1'b1;
                    if (state == S_MNACK) data_rd <= rx_sh;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_engine.sv
// tb_i2c_master_engine: table-driven bench with a bit-level I2C slave model.
module tb_i2c_master_engine;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] sub;
        logic [7:0] wd;
        logic [7:0] srd;
        bit         nack;
        bit         exp_err;
        logic [7:0] exp_rd;
        int         exp_cyc;
    } vec_t;

    localparam int NV = 6;
    localparam int T_START = 256;
    localparam int T_STOP  = 257;
    localparam int T_ACK   = 258;
    localparam int T_NACK  = 259;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] sub_addr = 8'h00;
    logic [7:0] data_wr = 8'h00;
    logic [7:0] data_rd;
    logic       busy;
    logic       ack_err;
    logic       sda_in;
    logic       scl_in;
    logic       sda_oe;
    logic       scl_oe;

    bit         slave_low = 1'b0;
    bit         stretch = 1'b0;
    bit         dev_nack = 1'b0;
    logic [7:0] slave_tx = 8'h00;
    int         tr_q[$];
    int         exp_q[$];
    int         rel_cnt = 0;
    int         stretch_at = 0;
    int         stretch_base = 0;
    int         stretch_left = 0;
    int         n_pass = 0;
    int         n_total = 0;

    assign scl_in = !(scl_oe || stretch);
    assign sda_in = !(sda_oe || slave_low);

    i2c_master_engine #(
        .CLK_FREQ_HZ(1600000),
        .I2C_FREQ_HZ(100000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .addr    (addr),
        .sub_addr(sub_addr),
        .data_wr (data_wr),
        .data_rd (data_rd),
        .busy    (busy),
        .ack_err (ack_err),
        .sda_in  (sda_in),
        .scl_in  (scl_in),
        .sda_oe  (sda_oe),
        .scl_oe  (scl_oe)
    );

    always #5 clk = ~clk;

    // Slave model: decodes the bus, logs tokens, ACKs device 0x60 and serves reads.
    bit         pscl = 1'b1;
    bit         psda = 1'b1;
    bit         pscl_oe = 1'b0;
    int         bitn = 0;
    bit         is_addr = 1'b0;
    bit         rd_mode = 1'b0;
    logic [7:0] rx = 8'h00;

    always @(negedge clk) begin
        bit s_scl;
        bit s_sda;
        bit ackd;
        if (stretch_left > 0) begin
            stretch_left--;
            if (stretch_left == 0) stretch = 1'b0;
        end
        if (pscl_oe && !scl_oe) begin
            rel_cnt++;
            if (stretch_at != 0 && rel_cnt - stretch_base == stretch_at) begin
                stretch = 1'b1;
                stretch_left = 500;
            end
        end
        pscl_oe = scl_oe;
        s_scl = !(scl_oe || stretch);
        s_sda = !(sda_oe || slave_low);
        if (pscl && s_scl && psda && !s_sda) begin
            tr_q.push_back(T_START);
            bitn = 0; is_addr = 1'b1; rd_mode = 1'b0; slave_low = 1'b0;
        end else if (pscl && s_scl && !psda && s_sda) begin
            tr_q.push_back(T_STOP);
            bitn = 0; rd_mode = 1'b0; slave_low = 1'b0;
        end else if (!pscl && s_scl) begin
            if (bitn < 8) begin
                rx = {rx[6:0], s_sda};
                bitn++;
                if (bitn == 8) tr_q.push_back(int'(rx));
            end else if (bitn == 8) begin
                tr_q.push_back(s_sda ? T_NACK : T_ACK);
                bitn = 9;
            end
        end else if (pscl && !s_scl) begin
            if (bitn == 8) begin
                if (rd_mode) begin
                    slave_low = 1'b0;
                end else begin
                    ackd = !is_addr || (rx[7:1] == 7'h60 && !dev_nack);
                    slave_low = ackd;
                    if (is_addr && ackd && rx[0]) rd_mode = 1'b1;
                end
            end else if (bitn == 9) begin
                if (rd_mode && is_addr) begin
                    slave_low = !slave_tx[7];
                end else begin
                    rd_mode = 1'b0;
                    slave_low = 1'b0;
                end
                is_addr = 1'b0;
                bitn = 0;
            end else if (rd_mode && bitn > 0 && bitn < 8) begin
                slave_low = !slave_tx[7-bitn];
            end
        end
        pscl = s_scl;
        psda = s_sda;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      nm, act, act, exp, exp);
    endtask

    function automatic void build_exp(input vec_t v);
        exp_q.push_back(T_START);
        exp_q.push_back(int'({v.addr[7:1], 1'b0}));
        if (v.nack) begin
            exp_q.push_back(T_NACK);
            exp_q.push_back(T_STOP);
            return;
        end
        exp_q.push_back(T_ACK);
        exp_q.push_back(int'(v.sub));
        exp_q.push_back(T_ACK);
        if (v.addr[0]) begin
            exp_q.push_back(T_START);
            exp_q.push_back(int'({v.addr[7:1], 1'b1}));
            exp_q.push_back(T_ACK);
            exp_q.push_back(int'(v.srd));
            exp_q.push_back(T_NACK);
        end else begin
            exp_q.push_back(int'(v.wd));
            exp_q.push_back(T_ACK);
        end
        exp_q.push_back(T_STOP);
    endfunction

    task automatic check_trace(input string nm, input int base);
        int n;
        int bad;
        n = tr_q.size() - base;
        bad = -1;
        chk({nm, "_len"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            if (bad < 0 && tr_q[base+i] != exp_q[i]) bad = i;
        chk({nm, "_tok_bad_idx"}, bad, -1);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_txn(input vec_t v, output int cyc);
        dev_nack = v.nack;
        slave_tx = v.srd;
        addr = v.addr;
        sub_addr = v.sub;
        data_wr = v.wd;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        wait_idle(cyc);
        repeat (3) @(negedge clk);
    endtask

    vec_t vecs[NV];
    vec_t vw;
    vec_t vr;

    initial begin
        int cyc;
        int gap;
        int base;
        int rb;
        int t;

        vecs[0] = '{8'hC0, 8'h26, 8'hB8, 8'h00, 1'b0, 1'b0, 8'h00, 465};
        vecs[1] = '{8'hC1, 8'h01, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h5A, 625};
        vecs[2] = '{8'hC0, 8'h26, 8'hB8, 8'h00, 1'b1, 1'b1, 8'h5A, 177};
        vecs[3] = '{8'hC1, 8'h01, 8'h00, 8'h33, 1'b1, 1'b1, 8'h5A, 177};
        vecs[4] = '{8'hC1, 8'h0F, 8'h00, 8'hA5, 1'b0, 1'b0, 8'hA5, 625};
        vecs[5] = '{8'hC0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'hA5, 465};
        vw = vecs[0];
        vr = '{8'hC1, 8'h01, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h5A, 625};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_data_rd", data_rd, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_scl_oe", scl_oe, 0);

        for (int i = 0; i < NV; i++) begin
            exp_q.delete();
            build_exp(vecs[i]);
            base = tr_q.size();
            run_txn(vecs[i], cyc);
            chk($sformatf("v%0d_ack_err", i), ack_err, vecs[i].exp_err);
            chk($sformatf("v%0d_data_rd", i), data_rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_busy_cyc", i), cyc, vecs[i].exp_cyc);
            check_trace($sformatf("v%0d_trace", i), base);
        end

        // second command while busy must be ignored
        exp_q.delete();
        build_exp(vw);
        base = tr_q.size();
        dev_nack = 1'b0;
        addr = vw.addr; sub_addr = vw.sub; data_wr = vw.wd;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        repeat (100) @(negedge clk);
        addr = 8'hC1; sub_addr = 8'h01; data_wr = 8'h55; slave_tx = 8'h99;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        wait_idle(cyc);
        repeat (5) @(negedge clk);
        chk("tog_busy_cyc", cyc, 364);
        chk("tog_ack_err", ack_err, 0);
        chk("tog_data_rd", data_rd, 8'hA5);
        chk("tog_idle_after", busy, 0);
        check_trace("tog_trace", base);

        // ena held high: back-to-back transactions
        exp_q.delete();
        build_exp(vw);
        build_exp(vw);
        base = tr_q.size();
        addr = vw.addr; sub_addr = vw.sub; data_wr = vw.wd;
        ena = 1'b1;
        @(negedge clk);
        wait_idle(cyc);
        chk("b2b_first_cyc", cyc, 465);
        gap = 0;
        while (!busy && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        ena = 1'b0;
        chk("b2b_gap", gap, 1);
        wait_idle(cyc);
        repeat (3) @(negedge clk);
        chk("b2b_second_cyc", cyc, 465);
        check_trace("b2b_trace", base);

        // reset during SUB bit 4 (13th SCL release)
        dev_nack = 1'b0;
        slave_tx = 8'h5A;
        addr = 8'hC1; sub_addr = 8'h01;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        rb = rel_cnt;
        t = 0;
        while (rel_cnt - rb < 13 && t < 5000) begin
            t++;
            @(negedge clk);
        end
        chk("rmid_reach_bit4", int'(t < 5000), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rmid_sda_oe", sda_oe, 0);
        chk("rmid_scl_oe", scl_oe, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_ack_err", ack_err, 0);
        chk("rmid_data_rd", data_rd, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.delete();
        build_exp(vr);
        base = tr_q.size();
        run_txn(vr, cyc);
        chk("rnew_ack_err", ack_err, 0);
        chk("rnew_data_rd", data_rd, 8'h5A);
        chk("rnew_busy_cyc", cyc, 625);
        check_trace("rnew_trace", base);

`ifdef I2C_CLOCK_STRETCH_EN
        // slave stretches SCL for 500 clocks in the ACK_S slot (18th release)
        exp_q.delete();
        build_exp(vw);
        base = tr_q.size();
        stretch_base = rel_cnt;
        stretch_at = 18;
        run_txn(vw, cyc);
        stretch_at = 0;
        chk("st_busy_cyc", cyc, 965);
        chk("st_ack_err", ack_err, 0);
        check_trace("st_trace", base);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2c_master_engine.md
Name: i2c_master_engine

Overview:
- Byte-level I2C master that executes one register transaction per command from the altimeter controller: write one byte to a sub-address, or read one byte from a sub-address.
- Accepts the command interface (ena, addr, sub_addr, data_wr) and returns data_rd, busy and ack_err.
- Drives open-drain SCL/SDA toward the pressure/temperature sensor. Sits between the controller and the board pins.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- I2C_FREQ_HZ, 100000, SCL frequency.
- QDIV, CLK_FREQ_HZ/(4*I2C_FREQ_HZ), clocks per quarter SCL period (derived localparam, minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ena  in  1  command request; sampled only while busy=0.
- addr  in  8  [7:1] 7-bit device address, [0] R/W (1 = read).
- sub_addr  in  8  register address.
- data_wr  in  8  write data (ignored on read).
- data_rd  out  8  read result; valid from busy falling edge until next command.
- busy  out  1  transaction in progress.
- ack_err  out  1  a NACK was seen in the last transaction.
- sda_in  in  1  synchronized SDA pin level.
- scl_in  in  1  synchronized SCL pin level (used only with the optional feature).
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- scl_oe  out  1  1 = pull SCL low, 0 = release.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: busy=0, ack_err=0, data_rd=8'h00, sda_oe=0, scl_oe=0, state=IDLE, quarter counter=0.
- Reset mid-transaction releases both lines on the next edge. No STOP is generated.
- Command capture: when ena=1 and busy=0 on a clk edge, latch addr, sub_addr and data_wr, and clear ack_err.
  - busy=1 from the next cycle.
  - ena while busy=1 is ignored. ena held high after completion starts a new transaction.
- Timing: a quarter tick fires every QDIV clocks. Each bit spends four quarters:
  - Q0: SCL low, SDA changes.
  - Q1: SCL low.
  - Q2: SCL released.
  - Q3: SCL high, SDA sampled at the start of Q3.
- States:
  - IDLE
  - START: SDA falls while SCL is high.
  - ADDR_W: address byte with R/W=0, MSB first.
  - ACK_A
  - SUB: sub_addr byte.
  - ACK_S
  - write: WDATA (data_wr byte), then ACK_D, then STOP.
  - read: RSTART (repeated START), ADDR_R (address byte with R/W=1), ACK_R, RDATA (SDA released, 8 bits sampled MSB first), MNACK (master releases SDA as NACK), then STOP.
  - STOP: SDA rises while SCL is high.
  - DONE: busy drops.
- Bit counter is 3 bits. It counts 7 down to 0, and the byte ends when it wraps.
- Any ACK slot with SDA=1:
  - set ack_err=1 and go directly to STOP;
  - data_rd is unchanged.
- data_rd updates only after MNACK of a successful read.
- busy falls one cycle after the STOP's final quarter. ack_err stays valid while busy=0.

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- Defined: in Q2, the quarter counter is held while scl_in=0 after SCL is released. This supports slave clock stretching.
- Not defined: scl_in is ignored and timing is purely counter-based.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum;
  - quarter-phase encoding;
  - R/W bit constants I2C_WR=0 and I2C_RD=1;
  - the QDIV calculation function.
- No sub-module is required. The quarter-tick generator may be split out as i2c_qtick (counter plus stretch hold) for reuse.

Test Plan:
- Write: ena pulse with addr=8'hC0, sub_addr=8'h26, data_wr=8'hB8, slave model ACKs.
  - Bus sequence START C0 A 26 A B8 A STOP.
  - busy high for ~29 bit times. ack_err=0.
- Read: addr=8'hC1, sub_addr=8'h01, slave returns 8'h5A.
  - Bus sequence START C0 A 01 A RSTART C1 A 5A NACK STOP.
  - data_rd=8'h5A at busy fall.
- Address NACK: slave does not respond to 8'hC0.
  - ack_err=1 after ACK_A, STOP follows immediately, no sub-address is sent, data_rd is unchanged.
- ena toggling during busy: a second command issued mid-transaction is ignored and the bus trace matches the first command only. With ena held high, a back-to-back second transaction starts after DONE.
- Reset mid-byte: assert rst during SUB bit 4.
  - Next cycle: sda_oe=0, scl_oe=0, busy=0, ack_err=0.
  - A new command then completes correctly.
- With I2C_CLOCK_STRETCH_EN: slave holds scl_in low for 500 clocks on ACK_S. The SCL-high phase is delayed by exactly that amount and the transaction completes with correct data.
